// File: rtl/mult_div.sv
// Iterative 32-step multiply / restoring divide unit beside EX.
// Presents {hi, lo} with a one-cycle done pulse, then returns to idle unconditionally.
module mult_div #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        flush,
  output logic        mult_div_done,
  output logic [63:0] mult_div_result
);

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  count;
  logic        sgn, s1, s2, dz;
  logic [31:0] op1_q, a_mag, b_mag;
  logic [63:0] acc;

  logic        is_mul, is_div, start_sgn, last;
  logic [31:0] mag1, mag2;
  logic [32:0] mul_sum;
  logic [63:0] mul_acc, div_acc, res_fix;
  logic [32:0] div_rs;
  logic [31:0] div_diff, quo, rem;

  assign is_mul    = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
  assign is_div    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign start_sgn = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  assign last      = (count == 6'(ITER - 1));
  assign mag1      = (start_sgn && operand_1[31]) ? -operand_1 : operand_1;
  assign mag2      = (start_sgn && operand_2[31]) ? -operand_2 : operand_2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    mult_div_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (!flush && is_mul)      state_nxt = S_MUL;
        else if (!flush && is_div) state_nxt = S_DIV;
      end
      S_MUL, S_DIV: begin
        if (flush)     state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        mult_div_done = !flush;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shift-add step: carry from the high-half add shifts into acc[63].
  assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (b_mag[0] ? a_mag : 32'd0)};
  assign mul_acc = {mul_sum, acc[31:1]};

  // Restoring step: the shifted remainder is < 2*divisor, so a passing
  // trial difference always fits in 32 bits.
  assign div_rs   = {acc[63:32], acc[31]};
  assign div_diff = div_rs[31:0] - a_mag;
  assign div_acc  = (div_rs >= {1'b0, a_mag}) ? {div_diff, acc[30:0], 1'b1}
                                              : {div_rs[31:0], acc[30:0], 1'b0};

  always_comb begin
    quo     = div_acc[31:0];
    rem     = div_acc[63:32];
    res_fix = mul_acc;
    if (state == S_MUL) begin
      if (sgn && (s1 ^ s2)) res_fix = -mul_acc;
    end else if (dz) begin
      res_fix = {op1_q, 32'hFFFF_FFFF};
    end else begin
      if (sgn && (s1 ^ s2)) quo = -div_acc[31:0];
      if (sgn && s1)        rem = -div_acc[63:32];
      res_fix = {rem, quo};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count           <= '0;
      sgn             <= 1'b0;
      s1              <= 1'b0;
      s2              <= 1'b0;
      dz              <= 1'b0;
      op1_q           <= '0;
      a_mag           <= '0;
      b_mag           <= '0;
      acc             <= '0;
      mult_div_result <= '0;
    end else begin
      if (state == S_IDLE && state_nxt != S_IDLE) begin
        sgn   <= start_sgn;
        s1    <= operand_1[31];
        s2    <= operand_2[31];
        dz    <= (operand_2 == 32'd0);
        op1_q <= operand_1;
        count <= '0;
        if (is_mul) begin
          a_mag <= mag1;
          b_mag <= mag2;
          acc   <= '0;
        end else begin
          a_mag <= mag2;
          b_mag <= '0;
          acc   <= {32'd0, mag1};
        end
      end else if (state == S_MUL) begin
        acc   <= mul_acc;
        b_mag <= b_mag >> 1;
        count <= count + 6'd1;
      end else if (state == S_DIV) begin
        acc   <= div_acc;
        count <= count + 6'd1;
      end
      if (state_nxt == S_DONE) mult_div_result <= res_fix;
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: latency, signed/unsigned results, div-by-zero,
// flush, mid-op reset and back-to-back operation.
module tb_mult_div;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] NOP   = 6'b100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  funct = NOP;
  logic [31:0] operand_1 = '0, operand_2 = '0;
  logic        flush = 1'b0;
  logic        mult_div_done;
  logic [63:0] mult_div_result;

  int vectors = 0;
  int miscompares = 0;

  mult_div #(.ITER(32)) dut (
    .clk(clk), .rst(rst), .funct(funct), .operand_1(operand_1),
    .operand_2(operand_2), .flush(flush), .mult_div_done(mult_div_done),
    .mult_div_result(mult_div_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start at edge E0 and count edges (E0 inclusive) until done is seen.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] res);
    @(negedge clk);
    funct = f; operand_1 = a; operand_2 = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    funct = NOP;
    while (!mult_div_done && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = mult_div_result;
  endtask

  task automatic idle_cycles(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mult_div_done) pulses++;
    end
  endtask

  int          lat, pulses, first_at, second_at;
  logic [63:0] res;

  initial begin
    #12;
    chk("reset_done", {63'd0, mult_div_done}, 64'd0);
    chk("reset_result", mult_div_result, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
    chk("multu_latency", 64'(lat), 64'd33);
    chk("multu_max", res, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, mult_div_done}, 64'd0);

    run_op(MULT, 32'hFFFF_FFFD, 32'd7, lat, res);
    chk("mult_neg3x7", res, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(MULT, 32'h8000_0000, 32'h8000_0000, lat, res);
    chk("mult_minxmin", res, 64'h4000_0000_0000_0000);
    run_op(DIVU, 32'd100, 32'd7, lat, res);
    chk("divu_100_7", res, 64'h0000_0002_0000_000E);
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, lat, res);
    chk("div_neg7_2", res, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    chk("div_min_neg1", res, 64'h0000_0000_8000_0000);
    run_op(DIVU, 32'h0000_1234, 32'd0, lat, res);
    chk("divu_by0_latency", 64'(lat), 64'd33);
    chk("divu_by0", res, 64'h0000_1234_FFFF_FFFF);
    run_op(DIV, 32'hFFFF_FF00, 32'd0, lat, res);
    chk("div_by0_latency", 64'(lat), 64'd33);
    chk("div_by0", res, 64'hFFFF_FF00_FFFF_FFFF);

    // Flush at iteration 10: no done, result holds the div-by-zero value.
    @(negedge clk);
    funct = MULTU; operand_1 = 32'h1111_1111; operand_2 = 32'd3;
    @(negedge clk);
    funct = NOP;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle_cycles(40, pulses);
    chk("flush_no_done", 64'(pulses), 64'd0);
    chk("flush_result_held", mult_div_result, 64'hFFFF_FF00_FFFF_FFFF);
    run_op(MULT, 32'd6, 32'd7, lat, res);
    chk("after_flush_latency", 64'(lat), 64'd33);
    chk("after_flush_6x7", res, 64'h0000_0000_0000_002A);

    // Start coinciding with flush is ignored.
    @(negedge clk);
    funct = MULT; operand_1 = 32'd9; operand_2 = 32'd9; flush = 1'b1;
    @(negedge clk);
    funct = NOP; flush = 1'b0;
    idle_cycles(40, pulses);
    chk("flush_start_ignored", 64'(pulses), 64'd0);

    // Unrecognised funct held in idle does nothing.
    @(negedge clk);
    funct = 6'b100001;
    idle_cycles(40, pulses);
    funct = NOP;
    chk("nop_no_done", 64'(pulses), 64'd0);
    chk("nop_result_held", mult_div_result, 64'h0000_0000_0000_002A);

    // Reset asserted at iteration 20 clears outputs at once.
    @(negedge clk);
    funct = MULTU; operand_1 = 32'hDEAD_BEEF; operand_2 = 32'h1234_5678;
    @(negedge clk);
    funct = NOP;
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_result", mult_div_result, 64'd0);
    chk("rst_mid_done", {63'd0, mult_div_done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(40, pulses);
    chk("rst_mid_no_done", 64'(pulses), 64'd0);

    // Back-to-back MULTU with funct held: pulses 34 cycles apart.
    first_at = 0; second_at = 0; pulses = 0;
    @(negedge clk);
    funct = MULTU; operand_1 = 32'd3; operand_2 = 32'd5;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (mult_div_done) begin
        pulses++;
        if (pulses == 1) first_at = i;
        else if (pulses == 2) second_at = i;
      end
    end
    funct = NOP;
    chk("b2b_pulse_count", 64'(pulses), 64'd2);
    chk("b2b_first_at", 64'(first_at), 64'd33);
    chk("b2b_spacing", 64'(second_at - first_at), 64'd34);
    chk("b2b_result", mult_div_result, 64'h0000_0000_0000_000F);
    idle_cycles(40, pulses);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
